// File: rtl/seg_msg_pkg.sv
// Shared character codes, FSM state type and the blank segment pattern
// for the seven-segment message scroller.
package seg_msg_pkg;

    localparam logic [4:0] CHAR_R     = 5'd16;
    localparam logic [4:0] CHAR_D     = 5'd17;
    localparam logic [4:0] CHAR_T     = 5'd18;
    localparam logic [4:0] CHAR_US    = 5'd19;
    localparam logic [4:0] CHAR_DASH  = 5'd20;
    localparam logic [4:0] CHAR_BLANK = 5'd21;

    localparam logic [7:0] BLANK_SEG  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        SCROLL
    } state_t;

endpackage

// File: rtl/hexDriver.sv
// Combinational 5-bit character code to active-low {dp,g,f,e,d,c,b,a} segments.
// Zero latency, no flow control; DP is always off and unknown codes are blank.
module hexDriver
    import seg_msg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = BLANK_SEG;
        case (code_i)
            5'd0:       seg_o = 8'hC0;
            5'd1:       seg_o = 8'hF9;
            5'd2:       seg_o = 8'hA4;
            5'd3:       seg_o = 8'hB0;
            5'd4:       seg_o = 8'h99;
            5'd5:       seg_o = 8'h92;
            5'd6:       seg_o = 8'h82;
            5'd7:       seg_o = 8'hF8;
            5'd8:       seg_o = 8'h80;
            5'd9:       seg_o = 8'h90;
            5'd10:      seg_o = 8'h88;
            5'd11:      seg_o = 8'h83;
            5'd12:      seg_o = 8'hC6;
            5'd13:      seg_o = 8'hA1;
            5'd14:      seg_o = 8'h86;
            5'd15:      seg_o = 8'h8E;
            CHAR_R:     seg_o = 8'hAF;
            CHAR_D:     seg_o = 8'hA1;
            CHAR_T:     seg_o = 8'h87;
            CHAR_US:    seg_o = 8'hF7;
            CHAR_DASH:  seg_o = 8'hBF;
            default:    seg_o = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/seg_msg_scroller.sv
// Message buffer, IDLE/SHOW/SCROLL FSM, tick/blink counters and window mux feeding HEX digits.
// Load shows on hex one cycle after acceptance; msg_ready only gates loads during SCROLL when SYNC_LOAD=1.
module seg_msg_scroller
    import seg_msg_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int MSG_LEN   = 16,
    parameter int CHAR_W    = 5,
    parameter int TICK_DIV  = 25_000_000,
    parameter int BLINK_DIV = 12_500_000,
    parameter int SYNC_LOAD = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            msg_valid,
    output logic                            msg_ready,
    input  logic [MSG_LEN*CHAR_W-1:0]       msg_data,
    input  logic [$clog2(MSG_LEN+1)-1:0]    msg_len,
    input  logic [1:0]                      mode,
    output logic [N_DIGITS*8-1:0]           hex,
    output logic                            busy,
    output logic                            wrap_pulse
);

    localparam int LEN_W   = $clog2(MSG_LEN + 1);
    localparam int OFF_W   = $clog2(MSG_LEN + N_DIGITS);
    localparam int V_W     = $clog2(MSG_LEN + 2 * N_DIGITS);
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    state_t                      state_q, state_d;
    logic [MSG_LEN*CHAR_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic                        blink_en_q, blink_en_d;
    logic [OFF_W-1:0]            off_q, off_d;
    logic [TICK_W-1:0]           tick_q, tick_d;
    logic [BLINK_W-1:0]          blink_cnt_q, blink_cnt_d;
    logic                        phase_q, phase_d;
    logic [N_DIGITS*8-1:0]       hex_q, hex_d;
    logic                        busy_q, busy_d;
    logic                        wrap_q, wrap_d;

    logic                        load;
    logic                        tick;
    logic                        blink_hit;
    logic [LEN_W-1:0]            len_clamp;
    logic [V_W-1:0]              virt_len;
    logic [V_W-1:0]              pos;
    logic [4:0]                  code [N_DIGITS];
    logic [7:0]                  seg  [N_DIGITS];

    // Combinational so the wrap cycle itself can accept a synchronised load.
    assign msg_ready = !rst && ((SYNC_LOAD == 0) || (state_q != SCROLL) || wrap_q);
    assign load      = msg_valid && msg_ready;
    assign tick      = (tick_q == TICK_W'(TICK_DIV - 1));
    assign blink_hit = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign len_clamp = (msg_len > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : msg_len;
    assign virt_len  = V_W'(len_q) + V_W'(N_DIGITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            len_q       <= '0;
            blink_en_q  <= 1'b0;
            off_q       <= '0;
            tick_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hex_q       <= {N_DIGITS{BLANK_SEG}};
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            blink_en_q  <= blink_en_d;
            off_q       <= off_d;
            tick_q      <= tick_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hex_q       <= hex_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        len_d       = len_q;
        blink_en_d  = blink_en_q;
        off_d       = off_q;
        tick_d      = tick ? '0 : tick_q + TICK_W'(1);
        blink_cnt_d = blink_hit ? '0 : blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q ^ blink_hit;
        wrap_d      = 1'b0;

        if (state_q == SCROLL && tick) begin
            if (V_W'(off_q) == virt_len - V_W'(1)) begin
                off_d  = '0;
                wrap_d = 1'b1;
            end else begin
                off_d  = off_q + OFF_W'(1);
            end
        end

        // A load overrides any tick or wrap in the same cycle.
        if (load) begin
            buf_d       = msg_data;
            len_d       = len_clamp;
            blink_en_d  = mode[1];
            off_d       = '0;
            tick_d      = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
            wrap_d      = 1'b0;
            if (len_clamp == '0)
                state_d = IDLE;
            else if (mode[0] && (int'(len_clamp) > N_DIGITS))
                state_d = SCROLL;
            else
                state_d = SHOW;
        end
    end

    // SHOW is the offset-0 window; positions past len fall in the blank tail.
    always_comb begin
        pos = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            pos = V_W'(off_q) + V_W'(N_DIGITS - 1 - d);
            if (pos >= virt_len)
                pos = pos - virt_len;
            code[d] = CHAR_BLANK;
            for (int i = 0; i < MSG_LEN; i++) begin
                if (pos == V_W'(i) && pos < V_W'(len_q))
                    code[d] = 5'(buf_q[i*CHAR_W +: CHAR_W]);
            end
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_hex
        hexDriver u_hex (
            .code_i (code[g]),
            .seg_o  (seg[g])
        );
    end

    always_comb begin
        hex_d  = '0;
        busy_d = (state_q == SCROLL);
        for (int d = 0; d < N_DIGITS; d++) begin
            if (state_q == IDLE || (blink_en_q && phase_q))
                hex_d[d*8 +: 8] = BLANK_SEG;
            else
                hex_d[d*8 +: 8] = seg[d];
        end
    end

    assign hex        = hex_q;
    assign busy       = busy_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Directed bench for seg_msg_scroller: one free-running instance and one with synchronised loads.
module tb_seg_msg_scroller;

    localparam logic [47:0] ALL_BLANK = {6{8'hFF}};
    localparam logic [47:0] READ0_HEX = 48'hAF8688A1F7C0;
    localparam logic [47:0] ABC_HEX   = 48'h8883C6FFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        va = 1'b0, vb = 1'b0;
    logic        ra, rb;
    logic [79:0] da = '0, db = '0;
    logic [4:0]  la = '0, lb = '0;
    logic [1:0]  ma = '0, mb = '0;
    logic [47:0] hex_a, hex_b;
    logic        busy_a, busy_b, wrap_a, wrap_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg_msg_scroller #(
        .N_DIGITS(6), .MSG_LEN(16), .CHAR_W(5),
        .TICK_DIV(4), .BLINK_DIV(3), .SYNC_LOAD(0)
    ) dut_a (
        .clk(clk), .rst(rst),
        .msg_valid(va), .msg_ready(ra), .msg_data(da), .msg_len(la), .mode(ma),
        .hex(hex_a), .busy(busy_a), .wrap_pulse(wrap_a)
    );

    seg_msg_scroller #(
        .N_DIGITS(6), .MSG_LEN(16), .CHAR_W(5),
        .TICK_DIV(4), .BLINK_DIV(3), .SYNC_LOAD(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .msg_valid(vb), .msg_ready(rb), .msg_data(db), .msg_len(lb), .mode(mb),
        .hex(hex_b), .busy(busy_b), .wrap_pulse(wrap_b)
    );

    function automatic logic [7:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:  return 8'hC0;  5'd1:  return 8'hF9;  5'd2:  return 8'hA4;
            5'd3:  return 8'hB0;  5'd4:  return 8'h99;  5'd5:  return 8'h92;
            5'd6:  return 8'h82;  5'd7:  return 8'hF8;  5'd8:  return 8'h80;
            5'd9:  return 8'h90;  5'd10: return 8'h88;  5'd11: return 8'h83;
            5'd12: return 8'hC6;  5'd13: return 8'hA1;  5'd14: return 8'h86;
            5'd15: return 8'h8E;  5'd16: return 8'hAF;  5'd17: return 8'hA1;
            5'd18: return 8'h87;  5'd19: return 8'hF7;  5'd20: return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected scroll window: digit d shows virtual position (off + 5 - d) mod (len + 6).
    function automatic logic [47:0] exp_win(input logic [79:0] m, input int len, input int off);
        logic [47:0] r;
        int p;
        r = '0;
        for (int d = 0; d < 6; d++) begin
            p = (off + 5 - d) % (len + 6);
            r[d*8 +: 8] = (p < len) ? glyph(m[p*5 +: 5]) : 8'hFF;
        end
        return r;
    endfunction

    function automatic logic [79:0] seq_msg(input int n);
        logic [79:0] m;
        m = {16{5'd21}};
        for (int i = 0; i < n; i++) m[i*5 +: 5] = 5'(i);
        return m;
    endfunction

    function automatic logic [79:0] abc_msg();
        logic [79:0] m;
        m = {16{5'd21}};
        m[4:0] = 5'd10; m[9:5] = 5'd11; m[14:10] = 5'd12;
        return m;
    endfunction

    task automatic load_a(input logic [79:0] d, input logic [4:0] l, input logic [1:0] md);
        @(negedge clk);
        da = d; la = l; ma = md; va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0;
    endtask

    task automatic load_b(input logic [79:0] d, input logic [4:0] l, input logic [1:0] md);
        @(negedge clk);
        db = d; lb = l; mb = md; vb = 1'b1;
        @(posedge clk);
        #1 vb = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (ra !== 1'b0) $display("FAIL reset_ready_a got %b want 0", ra); else n_pass++;
        n_chk++; if (rb !== 1'b0) $display("FAIL reset_ready_b got %b want 0", rb); else n_pass++;
        n_chk++; if (hex_a !== ALL_BLANK) $display("FAIL reset_hex got %h want %h", hex_a, ALL_BLANK); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
        n_chk++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap_a); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++; if (ra !== 1'b1) $display("FAIL ready_after_reset got %b want 1", ra); else n_pass++;
    endtask

    task automatic test_static();
        logic [79:0] m;
        m = {16{5'd21}};
        m[4:0] = 5'd16; m[9:5] = 5'd14; m[14:10] = 5'd10;
        m[19:15] = 5'd17; m[24:20] = 5'd19; m[29:25] = 5'd0;
        load_a(m, 5'd6, 2'b00);
        @(negedge clk);
        n_chk++; if (hex_a !== ALL_BLANK) $display("FAIL static_latency got %h want %h", hex_a, ALL_BLANK); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            n_chk++; if (hex_a !== READ0_HEX) $display("FAIL static_hex[%0d] got %h want %h", i, hex_a, READ0_HEX); else n_pass++;
            n_chk++; if (busy_a !== 1'b0) $display("FAIL static_busy[%0d] got %b want 0", i, busy_a); else n_pass++;
        end
    endtask

    task automatic test_idle();
        load_a(seq_msg(4), 5'd0, 2'b00);
        @(posedge clk); @(negedge clk);
        n_chk++; if (hex_a !== ALL_BLANK) $display("FAIL idle_hex got %h want %h", hex_a, ALL_BLANK); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL idle_busy got %b want 0", busy_a); else n_pass++;
        load_a(abc_msg(), 5'd3, 2'b00);
        @(posedge clk); @(negedge clk);
        n_chk++; if (hex_a !== ABC_HEX) $display("FAIL abc_hex got %h want %h", hex_a, ABC_HEX); else n_pass++;
    endtask

    task automatic test_blink();
        logic [47:0] want;
        load_a(abc_msg(), 5'd3, 2'b10);
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); @(negedge clk);
            want = (((n - 1) / 3) % 2 == 1) ? ALL_BLANK : ABC_HEX;
            n_chk++; if (hex_a !== want) $display("FAIL blink_hex[%0d] got %h want %h", n, hex_a, want); else n_pass++;
        end
    endtask

    task automatic test_scroll(input logic [79:0] m, input logic [4:0] load_len, input int len, input int cycles);
        logic [47:0] want;
        int          v;
        v = len + 6;
        load_a(m, load_len, 2'b01);
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk); @(negedge clk);
            want = exp_win(m, len, ((n - 1) / 4) % v);
            n_chk++; if (hex_a !== want) $display("FAIL scroll_hex len%0d n%0d got %h want %h", len, n, hex_a, want); else n_pass++;
            n_chk++; if (wrap_a !== (n == 4 * v)) $display("FAIL scroll_wrap len%0d n%0d got %b want %b", len, n, wrap_a, (n == 4 * v)); else n_pass++;
            n_chk++; if (busy_a !== 1'b1) $display("FAIL scroll_busy len%0d n%0d got %b want 1", len, n, busy_a); else n_pass++;
        end
    endtask

    task automatic test_sync_load();
        logic [79:0] m;
        bit          accepted;
        m = seq_msg(8);
        accepted = 1'b0;
        load_b(m, 5'd8, 2'b01);
        db = abc_msg(); lb = 5'd3; mb = 2'b00; vb = 1'b1;
        for (int n = 0; n < 80 && !accepted; n++) begin
            @(negedge clk);
            if (rb) begin
                n_chk++; if (wrap_b !== 1'b1) $display("FAIL sync_ready_wrap got %b want 1", wrap_b); else n_pass++;
                n_chk++; if (n != 56) $display("FAIL sync_accept_cycle got %0d want 56", n); else n_pass++;
                accepted = 1'b1;
                @(posedge clk);
                #1 vb = 1'b0;
            end else begin
                n_chk++; if (wrap_b !== 1'b0) $display("FAIL sync_wait_wrap n%0d got %b want 0", n, wrap_b); else n_pass++;
            end
        end
        vb = 1'b0;
        n_chk++; if (!accepted) $display("FAIL sync_timeout got none want accept"); else n_pass++;
        @(negedge clk);
        n_chk++; if (hex_b !== exp_win(m, 8, 0)) $display("FAIL sync_old_hex got %h want %h", hex_b, exp_win(m, 8, 0)); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_chk++; if (hex_b !== ABC_HEX) $display("FAIL sync_new_hex got %h want %h", hex_b, ABC_HEX); else n_pass++;
        n_chk++; if (busy_b !== 1'b0) $display("FAIL sync_new_busy got %b want 0", busy_b); else n_pass++;
    endtask

    task automatic test_mid_reset();
        load_a(seq_msg(8), 5'd8, 2'b01);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_chk++; if (ra !== 1'b0) $display("FAIL midrst_ready_comb got %b want 0", ra); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_chk++; if (hex_a !== ALL_BLANK) $display("FAIL midrst_hex got %h want %h", hex_a, ALL_BLANK); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_a); else n_pass++;
        n_chk++; if (wrap_a !== 1'b0) $display("FAIL midrst_wrap got %b want 0", wrap_a); else n_pass++;
        n_chk++; if (ra !== 1'b0) $display("FAIL midrst_ready got %b want 0", ra); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_idle();
        test_blink();
        test_scroll(seq_msg(8), 5'd8, 8, 60);
        test_scroll(seq_msg(16), 5'd20, 16, 92);
        test_sync_load();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
